// File: rtl/encoder_4_2_stream_if.sv
// Valid/ready bus for the one-hot-to-binary encoder.
// The upstream producer and the downstream consumer share this bundle.
//   slave  : the encoder side. It receives i_* and drives o_*.
//   master : the environment side. It drives i_* and observes o_*.
//   Signals: i_valid/o_ready/i_one_hot form the upstream handshake.
//            o_valid/i_ready/o_binary/o_err form the downstream handshake.
//            i_clr_err and o_err_count control and report the error counter.
interface encoder_4_2_stream_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 2,
    parameter int unsigned CW = 8
);
    logic          i_valid;
    logic          o_ready;
    logic [N-1:0]  i_one_hot;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_binary;
    logic          o_err;
    logic          i_clr_err;
    logic [CW-1:0] o_err_count;

    modport slave (
        input  i_valid, i_one_hot, i_ready, i_clr_err,
        output o_ready, o_valid, o_binary, o_err, o_err_count
    );

    modport master (
        output i_valid, i_one_hot, i_ready, i_clr_err,
        input  o_ready, o_valid, o_binary, o_err, o_err_count
    );
endinterface

// File: rtl/encoder_4_2_stream.sv
// Registered one-hot-to-binary encoder with valid/ready handshakes on both sides.
// It flags every accepted word that is not exactly one-hot.
// It counts the flagged words in a saturating counter.
//   i_clk, i_rst_n : clock (rising edge) and asynchronous active-low reset.
//   bus (slave)    : upstream handshake  i_valid/o_ready/i_one_hot.
//                    downstream handshake o_valid/i_ready/o_binary/o_err.
//                    error counter        i_clr_err/o_err_count.
module encoder_4_2_stream #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 2,
    parameter int unsigned CW = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    encoder_4_2_stream_if.slave  bus
);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        state_q;
    logic [W-1:0]  binary_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;

    logic          in_fire;
    logic          out_fire;
    logic [W-1:0]  enc_idx;
    logic          enc_err;
    logic          seen_one;
    logic          seen_many;

    // Handshake: the output slot frees up in the same cycle it is consumed.
    assign bus.o_ready = (state_q == EMPTY) || bus.i_ready;
    assign in_fire     = bus.i_valid && bus.o_ready;
    assign out_fire    = (state_q == FULL) && bus.i_ready;

    // Lowest set bit wins; any word without exactly one set bit is erroneous.
    always_comb begin
        enc_idx   = '0;
        seen_one  = 1'b0;
        seen_many = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (bus.i_one_hot[j]) begin
                if (seen_one) begin
                    seen_many = 1'b1;
                end else begin
                    enc_idx  = W'(j);
                    seen_one = 1'b1;
                end
            end
        end
        enc_err = !seen_one || seen_many;
    end

    // Output slot state, result registers and the saturating error counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= EMPTY;
            binary_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (in_fire) begin
                state_q  <= FULL;
                binary_q <= enc_idx;
                err_q    <= enc_err;
            end else if (out_fire) begin
                state_q  <= EMPTY;
            end

            // A clear wins over a simultaneous erroneous accept.
            if (bus.i_clr_err) begin
                cnt_q <= '0;
            end else if (in_fire && enc_err && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign bus.o_valid     = (state_q == FULL);
    assign bus.o_binary    = binary_q;
    assign bus.o_err       = err_q;
    assign bus.o_err_count = cnt_q;

endmodule

// File: tb/tb_encoder_4_2_stream.sv
// Self-checking bench for encoder_4_2_stream.
// Two instances share one stimulus stream: one uses CW=8 and one uses CW=2.
// The CW=2 instance exercises counter saturation.
module tb_encoder_4_2_stream;
    logic i_clk;
    logic i_rst_n;

    encoder_4_2_stream_if #(.N(4), .W(2), .CW(8)) a ();
    encoder_4_2_stream_if #(.N(4), .W(2), .CW(2)) b ();

    assign b.i_valid   = a.i_valid;
    assign b.i_one_hot = a.i_one_hot;
    assign b.i_ready   = a.i_ready;
    assign b.i_clr_err = a.i_clr_err;

    encoder_4_2_stream #(.N(4), .W(2), .CW(8)) u_dut8 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (a)
    );

    encoder_4_2_stream #(.N(4), .W(2), .CW(2)) u_dut2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (b)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec;
    int n_err;

    // Reference model state
    int m_valid;
    int m_bin;
    int m_err;
    int m_cnt8;
    int m_cnt2;

    typedef struct {
        logic       v;
        logic [3:0] oh;
        logic       r;
        logic       c;
        int         e_valid;
        int         e_bin;
        int         e_err;
        int         e_cnt;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_bin = 0; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic chk_outputs();
        chk("o_valid",        int'(a.o_valid),     m_valid);
        chk("o_binary",       int'(a.o_binary),    m_bin);
        chk("o_err",          int'(a.o_err),       m_err);
        chk("o_err_count",    int'(a.o_err_count), m_cnt8);
        chk("o_err_count_cw2", int'(b.o_err_count), m_cnt2);
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic step(input logic v, input logic [3:0] oh, input logic r, input logic c);
        int  x;
        int  fire;
        int  e;
        a.i_valid   = v;
        a.i_one_hot = oh;
        a.i_ready   = r;
        a.i_clr_err = c;
        #1;
        chk("o_ready", int'(a.o_ready), ((m_valid == 0) || r) ? 1 : 0);
        @(posedge i_clk);
        fire = (v && ((m_valid == 0) || r)) ? 1 : 0;
        x    = int'(oh);
        e    = ($countones(oh) == 1) ? 0 : 1;
        if (fire != 0) begin
            m_valid = 1;
            m_bin   = (x == 0) ? 0 : $clog2(x & -x);
            m_err   = e;
        end else if ((m_valid != 0) && r) begin
            m_valid = 0;
        end
        if (c) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if ((fire != 0) && (e != 0)) begin
            m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
            m_cnt2 = (m_cnt2 + 1 > 3)   ? 3   : m_cnt2 + 1;
        end
        #1;
        chk_outputs();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();

        tbl[0]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1, 2, 0, 0};
        tbl[1]  = '{1'b1, 4'b0001, 1'b1, 1'b0, 1, 0, 0, 0};
        tbl[2]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 1, 1, 0, 0};
        tbl[3]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1, 2, 0, 0};
        tbl[4]  = '{1'b1, 4'b1000, 1'b1, 1'b0, 1, 3, 0, 0};
        tbl[5]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1, 0, 1, 1};
        tbl[6]  = '{1'b1, 4'b0110, 1'b1, 1'b0, 1, 1, 1, 2};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 0, 1, 1, 2};
        tbl[8]  = '{1'b1, 4'b1011, 1'b0, 1'b0, 1, 0, 1, 3};
        tbl[9]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 1, 0, 1, 0};
        tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 0, 1, 0};

        // Reset state
        i_rst_n     = 1'b0;
        a.i_valid   = 1'b0;
        a.i_one_hot = 4'b0000;
        a.i_ready   = 1'b0;
        a.i_clr_err = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_o_ready", int'(a.o_ready), 1);
        chk_outputs();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Table: single accept, back-to-back stream, errors, stall with clear
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].oh, tbl[i].r, tbl[i].c);
            chk("tbl_o_valid",     int'(a.o_valid),     tbl[i].e_valid);
            chk("tbl_o_binary",    int'(a.o_binary),    tbl[i].e_bin);
            chk("tbl_o_err",       int'(a.o_err),       tbl[i].e_err);
            chk("tbl_o_err_count", int'(a.o_err_count), tbl[i].e_cnt);
        end

        // Backpressure: 3 is held while the next word waits, then both move on one edge
        step(1'b1, 4'b1000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b0010, 1'b0, 1'b0);
            chk("stall_o_ready",  int'(a.o_ready),  0);
            chk("stall_o_binary", int'(a.o_binary), 3);
        end
        step(1'b1, 4'b0010, 1'b1, 1'b0);
        chk("release_o_binary", int'(a.o_binary), 1);
        chk("release_o_valid",  int'(a.o_valid),  1);

        // Saturation of the 2-bit counter, then clear beats a concurrent error
        step(1'b0, 4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 4'b1100, 1'b1, 1'b0);
        chk("sat_cw2", int'(b.o_err_count), 3);
        chk("sat_cw8", int'(a.o_err_count), 5);
        step(1'b1, 4'b0000, 1'b1, 1'b1);
        chk("clr_cw2",   int'(b.o_err_count), 0);
        chk("clr_cw8",   int'(a.o_err_count), 0);
        chk("clr_o_err", int'(a.o_err),       1);

        // Asynchronous reset while a result is stalled
        step(1'b1, 4'b1000, 1'b0, 1'b0);
        step(1'b1, 4'b0110, 1'b0, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_o_valid",     int'(a.o_valid),     0);
        chk("arst_o_binary",    int'(a.o_binary),    0);
        chk("arst_o_err_count", int'(a.o_err_count), 0);
        chk("arst_o_ready",     int'(a.o_ready),     1);
        a.i_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        step(1'b0, 4'b0100, 1'b1, 1'b0);
        chk("post_rst_o_valid", int'(a.o_valid), 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [3:0] oh;
            if ($urandom_range(0, 2) == 0) oh = 4'($urandom_range(0, 15));
            else                           oh = 4'(1 << $urandom_range(0, 3));
            step(1'($urandom_range(0, 3) != 0), oh,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
